// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps each instruction through its states and drives the datapath strobes.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_R     = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] FUNCT_JR = 6'h08;

  typedef enum logic [STATE_W-1:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JR        = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  ctrl_t  ctrl_next;
  logic   illegal_c;

  // Zero is consumed by the datapath together with PCWriteCond, not here.
  logic unused_zero;
  assign unused_zero = Zero;

  // I-type ALU operation and immediate extension, selected by opcode: {alu_op, ext_op}.
  function automatic logic [3:0] imm_alu(input logic [OP_W-1:0] op);
    logic [3:0] r;
    r = 4'b110_0;
    case (op)
      OP_ORI:  r = 4'b101_1;
      OP_ANDI: r = 4'b011_1;
      OP_LUI:  r = 4'b001_0;
      default: r = 4'b110_0;
    endcase
    return r;
  endfunction

  // Moore output table for one state.
  function automatic ctrl_t decode(input state_t st, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b110;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = 3'b110;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b010;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b111;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a           = 1'b1;
        c.alu_src_b           = 2'b10;
        {c.alu_op, c.ext_op}  = imm_alu(op);
      end
      S_I_WB: begin
        c.reg_write           = 1'b1;
        {c.alu_op, c.ext_op}  = imm_alu(op);
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b100;
        c.pc_source     = 2'b01;
        c.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_JR: begin
        c.pc_source = 2'b11;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; IllegalOp flags an unsupported opcode while decoding.
  always_comb begin
    next_state = S_FETCH;
    illegal_c  = 1'b0;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:                      next_state = S_MEM_ADDR;
          OP_R:                              next_state = (Funct == FUNCT_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  next_state = S_EXEC_I;
          OP_BEQ:                            next_state = S_BRANCH;
          OP_J:                              next_state = S_JUMP;
          default: begin
            next_state = S_FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  next_state = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state = S_MEM_WB;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: next_state = S_FETCH;
      S_EXEC_R:    next_state = S_R_WB;
      S_R_WB:      next_state = S_FETCH;
      S_EXEC_I:    next_state = S_I_WB;
      S_I_WB:      next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
      S_JR:        next_state = S_FETCH;
      default:     next_state = S_FETCH;
    endcase
  end

  // Outputs are decoded for the state being entered and registered alongside it,
  // so they stay aligned with State and clear asynchronously with reset.
  always_comb begin
    ctrl_next = '0;
    ctrl_next = decode(next_state, Opcode);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
    end else begin
      ctrl <= ctrl_next;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ExtOp       = ctrl.ext_op;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign IllegalOp   = illegal_c;
  assign State       = STATE_W'(state);

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath: the producer of the 3-bit `ALUOp` code consumed by the ALU control decoder, plus every datapath enable and mux select. It is driven by the instruction register's opcode and funct fields and by the ALU `Zero` flag. It steps each instruction through fetch, decode, execute, memory and write-back states, and asserts exactly the strobes each state requires.

## Interface
- `OP_*` localparams (not overridable): R=6'h00, J=6'h02, BEQ=6'h04, ADDI=6'h08, ANDI=6'h0C, ORI=6'h0D, LUI=6'h0F, LW=6'h23, SW=6'h2B; `FUNCT_JR`=6'h08.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `Opcode` in 6: IR[31:26]. Stable from the cycle after FETCH.
- `Funct` in 6: IR[5:0]. Used only to detect JR.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load qualified by `Zero` (the datapath ANDs it with `Zero`).
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead` out 1; `MemWrite` out 1; `IRWrite` out 1.
- `MemtoReg` out 1: 1 = MDR, 0 = ALUOut.
- `RegWrite` out 1.
- `RegDst` out 1: 1 = rd, 0 = rt.
- `ALUSrcA` out 1: 0 = PC, 1 = reg A.
- `ALUSrcB` out 2: 00 = reg B, 01 = 4, 10 = extended imm, 11 = sign-ext imm<<2.
- `ExtOp` out 1: 1 = zero-extend imm (ANDI/ORI), 0 = sign-extend.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A (JR).
- `ALUOp` out 3: 111 R-type, 110 add, 101 or, 011 and, 001 lui, 010 lw/sw add, 100 beq subtract.
- `IllegalOp` out 1: one-cycle pulse on unsupported opcode.
- `State` out 4: current state, for debug.

## Operation
- Moore FSM. All outputs decode from the current state only (except `IllegalOp`). Unlisted outputs are 0.
- States (encoding):
  - INIT(0): all outputs 0; next FETCH.
  - FETCH(1): MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=110, PCSource=00, PCWrite. Next DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=110 (branch target into ALUOut). Next by opcode:
    - LW/SW → MEM_ADDR
    - R with Funct=JR → JR
    - other R → EXEC_R
    - ADDI/ANDI/ORI/LUI → EXEC_I
    - BEQ → BRANCH
    - J → JUMP
    - anything else → FETCH with `IllegalOp`=1 for that one cycle.
  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=010. Next MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ(4): MemRead, IorD=1. Next MEM_WB.
  - MEM_WB(5): RegWrite, MemtoReg=1, RegDst=0. Next FETCH.
  - MEM_WRITE(6): MemWrite, IorD=1. Next FETCH.
  - EXEC_R(7): ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next R_WB.
  - R_WB(8): RegWrite, RegDst=1, MemtoReg=0. Next FETCH.
  - EXEC_I(9): ALUSrcA=1, ALUSrcB=10, with
    - ADDI: ALUOp=110
    - ORI: ALUOp=101, ExtOp=1
    - ANDI: ALUOp=011, ExtOp=1
    - LUI: ALUOp=001

    Next I_WB.
  - I_WB(10): RegWrite, RegDst=0, MemtoReg=0. ALUOp and ExtOp are held from EXEC_I. Next FETCH.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01, PCWriteCond. Next FETCH.
  - JUMP(12): PCSource=10, PCWrite. Next FETCH.
  - JR(13): PCSource=11, PCWrite. Next FETCH.
- Encodings 14–15 are unreachable. If entered, outputs are 0 and the next state is FETCH.
- I_WB needs `Opcode` to select ALUOp. `Opcode` is the IR field, which is stable until the next FETCH.

## Timing
- While `reset`=0: state=INIT and all outputs 0, regardless of `clk`.
- Reset deassertion: the first rising edge moves to FETCH. Reset asserted mid-instruction returns to INIT immediately; no write strobe survives the assertion.
- One state per cycle; there are no wait states.
- Cycles per instruction, FETCH through last state inclusive:
  - LW 5
  - R-type, I-type ALU, SW: 4
  - BEQ, J, JR, illegal: 3
- Write strobes (RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite) are high for exactly one cycle per instance.
- BEQ: `Zero` is sampled by the datapath at the BRANCH clock edge. Not taken costs the same 3 cycles.

## Test plan
- Reset: hold `reset`=0 across 3 edges → State=0, all outputs 0. Release → State=1 with MemRead=IRWrite=PCWrite=1, ALUSrcB=01, ALUOp=110.
- LW (Opcode=6'h23): State sequence 1,2,3,4,5,1. In state 3, ALUOp=010 and ALUSrcB=10. In state 4, MemRead=1 and IorD=1. RegWrite=1 and MemtoReg=1 only in state 5.
- R-type ADD (Opcode=0, Funct=6'h20): sequence 1,2,7,8,1, ALUOp=111 in state 7, RegWrite=1 and RegDst=1 in state 8. With Funct=6'h08: sequence 1,2,13,1, PCSource=11, PCWrite=1.
- ORI (6'h0D): state 9 shows ALUOp=101 and ExtOp=1. LUI (6'h0F): ALUOp=001 in states 9 and 10.
- BEQ (6'h04): state 11 shows ALUOp=100, PCWriteCond=1, PCSource=01, for both `Zero`=0 and `Zero`=1. 3 cycles back to FETCH.
- Illegal opcode 6'h3F: `IllegalOp`=1 in DECODE only, next state FETCH, no write strobe asserted. Also pull `reset` low in MEM_READ → INIT at once with all outputs 0.
